// File: rtl/banked_ram_read_port.sv
// Register-file RAM (2^ADDR_W x WIDTH) with a synchronous write port and a
// registered, stallable valid/ready read port. Optional write-to-read bypass
// on a same-cycle address collision.
module banked_ram_read_port #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] raddr,
    output logic              req_ready,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              rd_ready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             rd_valid_q;
    logic             rd_valid_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    logic             accept_c;
    logic [WIDTH-1:0] rd_word_c;

    // Output slot is free when empty or being drained this cycle.
    assign req_ready = !rd_valid_q || rd_ready;
    assign accept_c  = rd_req && req_ready;

    // Write port next state; writes are never stalled by the read side.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Word to capture on accept, with optional same-cycle write forwarding.
    always_comb begin
        rd_word_c = mem_q[raddr];
        if ((BYPASS != 0) && we && (waddr == raddr)) begin
            rd_word_c = wdata;
        end
    end

    // Output register: load on accept, drop valid on a drain with no refill.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (accept_c) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_word_c;
        end else if (rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    // Storage array state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_banked_ram_read_port.sv
// Directed bench for banked_ram_read_port; a BYPASS=1 and a BYPASS=0
// instance share every input so collision behaviour can be compared.
module tb_banked_ram_read_port;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [1:0] waddr;
    logic [1:0] wdata;
    logic       rd_req;
    logic [1:0] raddr;
    logic       rd_ready;

    logic       req_ready;
    logic       rd_valid;
    logic [1:0] rd_data;
    logic       req_ready_nb;
    logic       rd_valid_nb;
    logic [1:0] rd_data_nb;

    int pass_cnt  = 0;
    int total_cnt = 0;

    banked_ram_read_port #(.WIDTH(2), .ADDR_W(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .rd_req(rd_req), .raddr(raddr), .req_ready(req_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
    );

    banked_ram_read_port #(.WIDTH(2), .ADDR_W(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .rd_req(rd_req), .raddr(raddr), .req_ready(req_ready_nb),
        .rd_valid(rd_valid_nb), .rd_data(rd_data_nb), .rd_ready(rd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; waddr = 2'd0; wdata = 2'd0;
        rd_req = 1'b0; raddr = 2'd0; rd_ready = 1'b1;
        #2;
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", rd_valid);
        else pass_cnt++;
        total_cnt++;
        if (rd_data !== 2'd0) $display("FAIL reset_data got %0d want 0", rd_data);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %0b want 1", req_ready);
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL post_reset_req_ready got %0b want 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_read_zero();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            raddr  = 2'(i);
            #1;
            total_cnt++;
            if (req_ready !== 1'b1) $display("FAIL rz_req_ready[%0d] got %0b want 1", i, req_ready);
            else pass_cnt++;
            step();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== 2'd0)
                $display("FAIL rz_read[%0d] got v=%0b d=%0d want v=1 d=0", i, rd_valid, rd_data);
            else pass_cnt++;
        end
        rd_req = 1'b0;
        step();
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL rz_drain got %0b want 0", rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        for (int i = 3; i >= 0; i--) begin
            we = 1'b1; waddr = 2'(i); wdata = 2'(i);
            step();
        end
        we = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            raddr  = 2'(i);
            step();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== 2'(i))
                $display("FAIL wr_read[%0d] got v=%0b d=%0d want v=1 d=%0d", i, rd_valid, rd_data, i);
            else pass_cnt++;
        end
        rd_req = 1'b0;
        step();
    endtask

    task automatic test_hold();
        rd_req = 1'b1; raddr = 2'd2; rd_ready = 1'b1;
        step();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 2'd2)
            $display("FAIL hold_first got v=%0b d=%0d want v=1 d=2", rd_valid, rd_data);
        else pass_cnt++;
        // Stall with a competing request and a write to the held address.
        rd_ready = 1'b0; raddr = 2'd0;
        we = 1'b1; waddr = 2'd2; wdata = 2'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (req_ready !== 1'b0) $display("FAIL hold_req_ready[%0d] got %0b want 0", i, req_ready);
            else pass_cnt++;
            step();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== 2'd2)
                $display("FAIL hold_stable[%0d] got v=%0b d=%0d want v=1 d=2", i, rd_valid, rd_data);
            else pass_cnt++;
        end
        we = 1'b0; rd_req = 1'b0; rd_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL hold_release_ready got %0b want 1", req_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL hold_transfer got %0b want 0", rd_valid);
        else pass_cnt++;
        rd_req = 1'b1; raddr = 2'd2;
        step();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 2'd1)
            $display("FAIL hold_reread got v=%0b d=%0d want v=1 d=1", rd_valid, rd_data);
        else pass_cnt++;
        rd_req = 1'b0;
        step();
    endtask

    task automatic test_collision();
        we = 1'b1; waddr = 2'd1; wdata = 2'd3;
        rd_req = 1'b1; raddr = 2'd1; rd_ready = 1'b1;
        step();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 2'd3)
            $display("FAIL coll_bypass got v=%0b d=%0d want v=1 d=3", rd_valid, rd_data);
        else pass_cnt++;
        total_cnt++;
        if (rd_valid_nb !== 1'b1 || rd_data_nb !== 2'd1)
            $display("FAIL coll_nobypass got v=%0b d=%0d want v=1 d=1", rd_valid_nb, rd_data_nb);
        else pass_cnt++;
        we = 1'b0;
        step();
        total_cnt++;
        if (rd_data !== 2'd3) $display("FAIL coll_later_bypass got %0d want 3", rd_data);
        else pass_cnt++;
        total_cnt++;
        if (rd_data_nb !== 2'd3) $display("FAIL coll_later_nobypass got %0d want 3", rd_data_nb);
        else pass_cnt++;
        rd_req = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        rd_req = 1'b1; raddr = 2'd3; rd_ready = 1'b1;
        step();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 2'd3)
            $display("FAIL single_read got v=%0b d=%0d want v=1 d=3", rd_valid, rd_data);
        else pass_cnt++;
        rd_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if (rd_valid !== 1'b0) $display("FAIL single_idle[%0d] got %0b want 0", i, rd_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        we = 1'b1; waddr = 2'd0; wdata = 2'd2;
        step();
        we = 1'b0;
        rd_req = 1'b1; raddr = 2'd0; rd_ready = 1'b0;
        step();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 2'd2)
            $display("FAIL mid_pre got v=%0b d=%0d want v=1 d=2", rd_valid, rd_data);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_data !== 2'd0)
            $display("FAIL mid_reset got v=%0b d=%0d want v=0 d=0", rd_valid, rd_data);
        else pass_cnt++;
        total_cnt++;
        if (rd_valid_nb !== 1'b0 || rd_data_nb !== 2'd0)
            $display("FAIL mid_reset_nb got v=%0b d=%0d want v=0 d=0", rd_valid_nb, rd_data_nb);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL mid_reset_ready got %0b want 1", req_ready);
        else pass_cnt++;
        rd_req = 1'b0; rd_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        rd_req = 1'b1; raddr = 2'd0;
        step();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 2'd0)
            $display("FAIL mid_after got v=%0b d=%0d want v=1 d=0", rd_valid, rd_data);
        else pass_cnt++;
        rd_req = 1'b0; raddr = 2'd3;
        step();
        rd_req = 1'b1;
        step();
        total_cnt++;
        if (rd_data !== 2'd0) $display("FAIL mid_after_a3 got %0d want 0", rd_data);
        else pass_cnt++;
        rd_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_hold();
        test_collision();
        test_single_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
